// File: rtl/io_pkg.sv
// =============================================================================
// io_pkg: scan FSM states and sizing constants shared by the bit input scanner.
// Revision 1.0
// =============================================================================
`default_nettype none

package io_pkg;
  localparam int SHIFT_CYCLES = 16;
  localparam int NBITS        = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } scan_state_t;
endpackage

`default_nettype wire

// File: rtl/bit_input_scanner_if.sv
// =============================================================================
// bit_input_scanner_if: CPU read port and 74HC165 chain signals of the scanner.
// Revision 1.0
// =============================================================================
`default_nettype none

interface bit_input_scanner_if #(
  parameter int WIDTH_A = 3
);
  logic [WIDTH_A-1:0] A;
  logic               REb;
  logic               D;
  logic               SH_LDb;
  logic               SER_CLK;
  logic               SER_IN;
  logic               VALID;

  modport master (output A, REb, SER_IN, input D, SH_LDb, SER_CLK, VALID);
  modport slave  (input A, REb, SER_IN, output D, SH_LDb, SER_CLK, VALID);
endinterface

`default_nettype wire

// File: rtl/serial_shift_in.sv
// =============================================================================
// serial_shift_in: stores the k-th serial sample into bit NBITS-1-k.
// Revision 1.0
// =============================================================================
`default_nettype none

module serial_shift_in
  import io_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_en,
  input  logic [$clog2(NBITS)-1:0] sample_idx,
  input  logic                     ser_in,
  output logic [NBITS-1:0]         data
);
  logic [$clog2(NBITS)-1:0] bit_pos;

  // Chain delivers MSB first, so sample 0 lands in the top bit.
  assign bit_pos = $clog2(NBITS)'(NBITS - 1) - sample_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (sample_en) begin
      data[bit_pos] <= ser_in;
    end
  end
endmodule

`default_nettype wire

// File: rtl/bit_input_scanner.sv
// =============================================================================
// bit_input_scanner: periodic 74HC165 scan with snapshot read port.
// Optional sticky rising-edge latch: BIT_INPUT_SCANNER_EDGE_LATCH_EN. Rev 1.0
// =============================================================================
`default_nettype none

module bit_input_scanner
  import io_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter int WIDTH_A  = 3
) (
  input logic                clk,
  input logic                rst,
  bit_input_scanner_if.slave bus
);
  scan_state_t                state;
  logic [15:0]                idle_cnt;
  logic [3:0]                 shift_cnt;
  logic [NBITS-1:0]           shreg;
  logic [NBITS-1:0]           snapshot;
  logic                       sh_ldb;
  logic                       ser_clk;
  logic                       valid;
  logic                       d;
  logic                       sample_en;
  logic [$clog2(NBITS)-1:0]   sample_idx;
  logic [WIDTH_A-1:0]         addr;
  logic                       rd_bit;

  assign addr       = bus.A;
  assign sample_en  = (state == ST_SHIFT) && !shift_cnt[0];
  assign sample_idx = shift_cnt[3:1];

  serial_shift_in u_shift (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .sample_idx (sample_idx),
    .ser_in     (bus.SER_IN),
    .data       (shreg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idle_cnt  <= 16'(SCAN_DIV);
      shift_cnt <= '0;
      snapshot  <= '0;
      valid     <= 1'b0;
      sh_ldb    <= 1'b1;
      ser_clk   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (idle_cnt == 16'd1) begin
            state    <= ST_LOAD;
            idle_cnt <= 16'(SCAN_DIV);
            sh_ldb   <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt - 16'd1;
          end
        end
        ST_LOAD: begin
          state     <= ST_SHIFT;
          shift_cnt <= '0;
          sh_ldb    <= 1'b1;
        end
        ST_SHIFT: begin
          // Clock is high on odd shift cycles; the last cycle is odd, so it drops here.
          ser_clk <= ~shift_cnt[0];
          if (shift_cnt == 4'(SHIFT_CYCLES - 1)) begin
            state <= ST_COMMIT;
          end else begin
            shift_cnt <= shift_cnt + 4'd1;
          end
        end
        ST_COMMIT: begin
          snapshot <= shreg;
          valid    <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BIT_INPUT_SCANNER_EDGE_LATCH_EN
  logic [NBITS-1:0] sticky;
  logic [NBITS-1:0] sticky_set;
  logic [NBITS-1:0] sticky_clr;

  assign sticky_set = (state == ST_COMMIT) ? (shreg & ~snapshot) : '0;
  assign sticky_clr = bus.REb ? '0 : (NBITS'(1) << addr);
  assign rd_bit     = snapshot[addr] | sticky[addr];

  // A new rising edge wins over a read clearing the same bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky <= '0;
    end else begin
      sticky <= (sticky & ~sticky_clr) | sticky_set;
    end
  end
`else
  assign rd_bit = snapshot[addr];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d <= 1'b0;
    end else if (!bus.REb) begin
      d <= rd_bit;
    end
  end

  assign bus.D       = d;
  assign bus.SH_LDb  = sh_ldb;
  assign bus.SER_CLK = ser_clk;
  assign bus.VALID   = valid;
endmodule

`default_nettype wire

// File: doc/bit_input_scanner.md
BIT_INPUT_SCANNER -- requirements
Module: bit_input_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16: idle cycles between scans, legal range 1..65535.
REQ-002 SHALL have parameter WIDTH_A, default 3: read address width, fixed at 8 input bits.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port A, input, 3: bit address for CPU reads.
REQ-006 SHALL have port REb, input, 1: read enable, active-low, level-sensitive.
REQ-007 SHALL have port D, output, 1: the registered read data bit.
REQ-008 SHALL have port SH_LDb, output, 1: parallel-load strobe to an external 74HC165 chain, active-low.
REQ-009 SHALL have port SER_CLK, output, 1: shift clock to the external chain.
REQ-010 SHALL have port SER_IN, input, 1: serial data from the chain, MSB (bit 7) first.
REQ-011 SHALL have port VALID, output, 1: high once the first scan has committed.

Function
REQ-012 SHALL implement FSM IDLE -> LOAD -> SHIFT -> COMMIT -> IDLE.
REQ-013 IDLE SHALL last exactly SCAN_DIV cycles, counted by a 16-bit down-counter; SH_LDb=1, SER_CLK=0.
REQ-014 LOAD SHALL last 1 cycle with SH_LDb=0 and SER_CLK=0.
REQ-015 SHIFT SHALL last 16 cycles; on even cycles (0,2,..14) SER_CLK=0 and SER_IN is sampled at cycle end; on odd cycles SER_CLK=1.
REQ-016 The k-th sample (k=0..7) SHALL be stored into shift-register bit 7-k.
REQ-017 COMMIT SHALL last 1 cycle and copy the shift register into an 8-bit snapshot; VALID SHALL go high at the same edge and stay high until reset.
REQ-018 The scan period SHALL be SCAN_DIV+18 cycles, with no gap or overlap between scans.
REQ-019 When REb=0, D SHALL take snapshot[A] at the next rising edge (1-cycle latency); when REb=1, D SHALL hold its value.
REQ-020 A read coinciding with COMMIT SHALL return the pre-commit snapshot bit; the new value SHALL be visible one cycle later.
REQ-021 A and REb SHALL have no effect on scan timing.

Reset
REQ-022 While rst=1: state=IDLE, counter=SCAN_DIV, snapshot=0, shift register=0, D=0, VALID=0, SH_LDb=1, SER_CLK=0.
REQ-023 Reset asserted mid-SHIFT SHALL discard the partial scan; the snapshot SHALL NOT be updated.
REQ-024 After rst falls, the first LOAD SHALL occur SCAN_DIV cycles later.

Configuration
REQ-025 With macro BIT_INPUT_SCANNER_EDGE_LATCH_EN defined, an 8-bit sticky register SHALL be set per bit at COMMIT when the new snapshot bit is 1 and the old bit is 0.
REQ-026 With the macro, a read SHALL return snapshot[A] OR sticky[A] and clear sticky[A] at the same edge; a set and a clear on the same edge SHALL leave the bit set; reset SHALL clear the sticky register.
REQ-027 Without the macro, no sticky register SHALL exist and reads SHALL return snapshot[A] only.

Structure
REQ-028 The FSM state enum and the constants SHIFT_CYCLES=16 and NBITS=8 SHALL reside in the shared package io_pkg.
REQ-029 The serial shift/sample datapath SHALL be one sub-module, serial_shift_in; the FSM, snapshot and read port SHALL stay in the top level.

Verification
REQ-030 The bench SHALL run with SCAN_DIV=4 and a 165 model preset to 0xA5: after rst, LOAD at cycle 4; COMMIT at cycle 21; VALID=1 at cycle 22; reads with A=0..7 return 1,0,1,0,0,1,0,1.
REQ-031 The bench SHALL check periodicity: successive SH_LDb pulses are exactly 22 cycles apart over 10 scans.
REQ-032 The bench SHALL change inputs 0xA5 to 0x5A and read A=0 during the COMMIT cycle: D=1; a read on the next cycle gives D=0.
REQ-033 The bench SHALL assert rst at SHIFT cycle 7 with inputs at 0xFF after a prior snapshot of 0x00: snapshot stays 0x00, VALID=0, D=0.
REQ-034 With EDGE_LATCH_EN, the bench SHALL pulse input 3 from 0 to 1 for one scan and then back to 0: the first read of A=3 gives 1 and a second read gives 0.
REQ-035 The bench SHALL hold REb=1 across a COMMIT: D is unchanged.
